// File: rtl/pipeline_ld_controller_pkg.sv
// Shared types and constants for the pipeline load-enable sequencer.
// Holds the FSM encoding, the per-cycle control bundle and the NOP words that flushed/bubbled stages load.
package pipeline_ld_controller_pkg;

   localparam int REG_IDX_W = 5;
   localparam int STALL_W   = 32;

   // Words loaded into IF/ID on a flush and into ID/EX on a bubble
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] NOP_CTRL  = 32'h0000_0000;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } ld_state_e;

   typedef struct packed {
      logic pc_ld;
      logic ifid_ld;
      logic ifid_flush;
      logic idex_ld;
      logic idex_bubble;
      logic exmem_ld;
      logic memwb_ld;
   } ld_ctrl_t;

   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pipeline_ld_controller_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID instruction reads.
// Register 0 is hardwired, so a load targeting it never creates a dependency.
module pipeline_ld_controller_hazard_detect
   import pipeline_ld_controller_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_uses_rs,
   input  logic                 id_uses_rt,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] ex_rd,
   output logic                 load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit   = id_uses_rs && (id_rs == ex_rd);
   assign rt_hit   = id_uses_rt && (id_rt == ex_rd);
   assign load_use = ex_mem_read && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ld_controller.sv
// Load-enable sequencer for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB banks.
// Resolves memory freezes, load-use bubbles and taken-branch squashes; counts stalled cycles.
//
//   state       | meaning
//   ------------+--------------------------------------------------------------
//   ST_RUN      | pipeline advancing; a fresh mem_op starts the freeze here
//   ST_MEM_WAIT | remaining frozen cycles of a multi-cycle data-memory access
module pipeline_ld_controller
   import pipeline_ld_controller_pkg::*;
#(
   parameter int MEM_WAIT_CYCLES = 2,
   parameter int CNT_W           = 4
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_uses_rs,
   input  logic                 id_uses_rt,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 mem_op,
   input  logic                 branch_taken,
   output logic                 pc_ld,
   output logic                 ifid_ld,
   output logic                 ifid_flush,
   output logic                 idex_ld,
   output logic                 idex_bubble,
   output logic                 exmem_ld,
   output logic                 memwb_ld,
   output logic [STALL_W-1:0]   stall_cycles
);

   localparam bit               FREEZE_EN = (MEM_WAIT_CYCLES > 0);
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   ld_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               served_q, served_d;
   logic [STALL_W-1:0] stall_q;
   logic               load_use;
   logic               freeze_entry;
   logic               freeze;
   ld_ctrl_t           ctrl;

   pipeline_ld_controller_hazard_detect u_hazard (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   // served blocks the instruction already granted its wait from freezing again
   assign freeze_entry = FREEZE_EN && (state_q == ST_RUN) && mem_op && !served_q;
   assign freeze       = freeze_entry || (state_q == ST_MEM_WAIT);

   always_comb begin
      ctrl = '{pc_ld: 1'b1, ifid_ld: 1'b1, ifid_flush: 1'b0, idex_ld: 1'b1,
               idex_bubble: 1'b0, exmem_ld: 1'b1, memwb_ld: 1'b1};
      if (reset) begin
         ctrl = '{pc_ld: 1'b0, ifid_ld: 1'b0, ifid_flush: 1'b1, idex_ld: 1'b0,
                  idex_bubble: 1'b1, exmem_ld: 1'b0, memwb_ld: 1'b0};
      end else if (freeze) begin
         ctrl = '0;
      end else if (load_use) begin
         ctrl.pc_ld       = 1'b0;
         ctrl.ifid_ld     = 1'b0;
         ctrl.idex_bubble = 1'b1;
      end else if (branch_taken) begin
         ctrl.ifid_flush = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      served_d = served_q;
      if (ctrl.memwb_ld) begin
         served_d = 1'b0;
      end
      case (state_q)
         ST_RUN: begin
            if (freeze_entry) begin
               if (MEM_WAIT_CYCLES == 1) begin
                  served_d = 1'b1;
               end else begin
                  state_d = ST_MEM_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_MEM_WAIT: begin
            if (cnt_q > CNT_ONE) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d  = ST_RUN;
               served_d = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         cnt_q    <= '0;
         served_q <= 1'b0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         served_q <= served_d;
         if (!ctrl.pc_ld) begin
            stall_q <= sat_inc(stall_q);
         end
      end
   end

   assign pc_ld        = ctrl.pc_ld;
   assign ifid_ld      = ctrl.ifid_ld;
   assign ifid_flush   = ctrl.ifid_flush;
   assign idex_ld      = ctrl.idex_ld;
   assign idex_bubble  = ctrl.idex_bubble;
   assign exmem_ld     = ctrl.exmem_ld;
   assign memwb_ld     = ctrl.memwb_ld;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ld_controller.sv
// Scoreboard bench for pipeline_ld_controller: directed cases then random traffic,
// expected outputs from a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_ld_controller;

   localparam int MWC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        id_uses_rs, id_uses_rt, ex_mem_read, mem_op, branch_taken;
   logic        pc_ld, ifid_ld, ifid_flush, idex_ld, idex_bubble, exmem_ld, memwb_ld;
   logic [31:0] stall_cycles;

   pipeline_ld_controller #(.MEM_WAIT_CYCLES(MWC), .CNT_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .mem_op       (mem_op),
      .branch_taken (branch_taken),
      .pc_ld        (pc_ld),
      .ifid_ld      (ifid_ld),
      .ifid_flush   (ifid_flush),
      .idex_ld      (idex_ld),
      .idex_bubble  (idex_bubble),
      .exmem_ld     (exmem_ld),
      .memwb_ld     (memwb_ld),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   // ctl bit order: pc, ifid, flush, idex, bubble, exmem, memwb
   typedef struct {
      logic [6:0]  ctl;
      logic [31:0] stall;
      bit          chk_stall;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   // model: remaining frozen cycles of the current access, and whether the
   // instruction in MEM has already had its wait
   int          freeze_left = 0;
   bit          released    = 0;
   logic [31:0] m_stall     = '0;
   bit          stall_known = 0;

   task automatic step(input bit r, input bit mo, input bit bt, input bit emr,
                       input logic [4:0] erd, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt);
      exp_t e;
      bit   frz, lu;
      reset = r; mem_op = mo; branch_taken = bt; ex_mem_read = emr;
      ex_rd = erd; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      e.stall     = m_stall;
      e.chk_stall = stall_known;
      e.cyc       = cyc;
      if (r) begin
         e.ctl       = 7'b0010100;
         freeze_left = 0;
         released    = 0;
         m_stall     = '0;
         stall_known = 1;
      end else begin
         frz = (freeze_left > 0) || (mo && !released && MWC > 0);
         if (frz && freeze_left == 0) freeze_left = MWC;
         lu = emr && (erd != 5'd0) && ((urs && rs == erd) || (urt && rt == erd));
         if (frz)      e.ctl = 7'b0000000;
         else if (lu)  e.ctl = 7'b0001111;
         else if (bt)  e.ctl = 7'b1111011;
         else          e.ctl = 7'b1101011;
         if (frz) begin
            freeze_left--;
            if (freeze_left == 0) released = 1;
         end else begin
            released = 0;
         end
         if (!e.ctl[6] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      logic [6:0] got;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         got = {pc_ld, ifid_ld, ifid_flush, idex_ld, idex_bubble, exmem_ld, memwb_ld};
         checks++;
         if (got !== e.ctl) begin
            errors++;
            $display("FAIL ctl cyc=%0d got=%b want=%b", e.cyc, got, e.ctl);
         end
         if (e.chk_stall) begin
            checks++;
            if (stall_cycles !== e.stall) begin
               errors++;
               $display("FAIL stall_cycles cyc=%0d got=%h want=%h", e.cyc, stall_cycles, e.stall);
            end
         end
      end
   end

   initial begin
      reset = 1; mem_op = 0; branch_taken = 0; ex_mem_read = 0;
      ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      @(posedge clk);
      #1;

      // reset then release
      step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      idle(2);

      // load-use via rs, rd=0 load, load-use via rt, unused operand
      step(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0);
      idle(1);
      step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
      step(0, 0, 0, 1, 5'd3, 5'd0, 5'd3, 0, 1);
      step(0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 1);
      idle(1);

      // mem_op held: freeze, release, freeze, release
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      idle(1);

      // branch alone, then branch with load-use held for two cycles
      step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      step(0, 0, 1, 1, 5'd9, 5'd9, 5'd0, 1, 0);
      step(0, 0, 1, 0, 5'd0, 5'd9, 5'd0, 1, 0);
      idle(1);

      // freeze overrides load-use and branch
      for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 5'd7, 5'd7, 5'd7, 1, 1);
      step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      idle(1);

      // reset during second frozen cycle
      step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      idle(3);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
      idle(3);

      // saturation of the stall counter
      force dut.stall_q = 32'hFFFF_FFFD;
      release dut.stall_q;
      m_stall = 32'hFFFF_FFFD;
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 5'd2, 5'd2, 5'd0, 1, 0);
      idle(1);

      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
